// File: rtl/div_sequencer_if.sv
// Handshake bundle between main control and the multi-cycle divider.
interface div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, stall, done,
    input  quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, stall, done,
    output quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_sequencer.sv
// Restoring divider, one quotient bit per cycle, signed/unsigned,
// with explicit divide-by-zero reporting and a CPU stall output.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  div_sequencer_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dsr;
  logic [CW-1:0]    r_cnt;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_dbz;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dz;

  logic             w_dvd_neg;
  logic             w_dsr_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dsr_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_idle;

  assign w_idle    = (r_state == IDLE);
  assign w_dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
  assign w_dsr_neg = bus.is_signed & bus.divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -bus.dividend : bus.dividend;
  assign w_dsr_mag = w_dsr_neg ? -bus.divisor : bus.divisor;

  // rem < divisor keeps the trial within signed WIDTH+1 range
  assign w_shift = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dsr};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dsr   <= '0;
      r_cnt   <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_dbz   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_busy <= 1'b1;
            r_rem  <= '0;
            if (bus.divisor == '0) begin
              r_dvd   <= bus.dividend;
              r_dbz   <= 1'b1;
              r_qneg  <= 1'b0;
              r_rneg  <= 1'b0;
              r_state <= FIX;
            end else begin
              r_dvd   <= w_dvd_mag;
              r_dsr   <= w_dsr_mag;
              r_dbz   <= 1'b0;
              r_qneg  <= w_dvd_neg ^ w_dsr_neg;
              r_rneg  <= w_dvd_neg;
              r_cnt   <= CW'(WIDTH - 1);
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (!w_trial[WIDTH]) begin
            r_rem <= w_trial[WIDTH-1:0];
          end else begin
            r_rem <= w_shift[WIDTH-1:0];
          end
          r_dvd <= {r_dvd[WIDTH-2:0], ~w_trial[WIDTH]};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          if (r_dbz) begin
            r_quot <= '1;
            r_remo <= r_dvd;
            r_dz   <= 1'b1;
          end else begin
            r_quot <= r_qneg ? -r_dvd : r_dvd;
            r_remo <= r_rneg ? -r_rem : r_rem;
            r_dz   <= 1'b0;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.stall       = r_busy | (bus.start & w_idle);
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_remo;
  assign bus.div_by_zero = r_dz;
endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: directed divides, latency,
// stall length, ignored start, back-to-back and reset abort.
module tb_div_sequencer;
  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   stl_cnt;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           at;
    int           stl;
  } exp_t;

  exp_t sb[$];

  div_sequencer_if #(.WIDTH(W)) bus ();

  div_sequencer #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stl_cnt = 0;
    end else if (bus.done) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done at cyc %0d expected none",
                 cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", bus.quotient, e.q);
        chk("remainder", bus.remainder, e.r);
        chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dz});
        chk("latency", cyc, e.at);
        chk("stall_len", stl_cnt, e.stl);
        chk("busy_in_done", {31'd0, bus.busy}, 32'd0);
      end
      stl_cnt = bus.stall ? 1 : 0;
    end else if (bus.stall) begin
      stl_cnt++;
    end
  end

  task automatic do_div(input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] q,
                        input logic [W-1:0] r);
    exp_t e;
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    e.q   = q;
    e.r   = r;
    e.dz  = (b == '0);
    e.at  = cyc + ((b == '0) ? 1 : W + 1);
    e.stl = (b == '0) ? 2 : W + 2;
    sb.push_back(e);
  endtask

  task automatic wait_done;
    int k;
    k = 0;
    while (k < 100) begin
      @(posedge clk);
      #1;
      if (bus.done) break;
      k++;
    end
    if (k >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_done: got timeout expected done");
    end
  endtask

  initial begin
    cyc           = 0;
    n_tests       = 0;
    n_fail        = 0;
    stl_cnt       = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_q", bus.quotient, 32'd0);
    chk("rst_r", bus.remainder, 32'd0);
    chk("rst_dz", {31'd0, bus.div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_div(1'b0, 32'd100, 32'd5, 32'd20, 32'd0);
    chk("busy_run", {31'd0, bus.busy}, 32'd1);
    wait_done();
    @(posedge clk); #1;
    do_div(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    wait_done();
    @(posedge clk); #1;
    do_div(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
    wait_done();
    @(posedge clk); #1;
    do_div(1'b0, 32'd100, 32'd0, 32'hFFFFFFFF, 32'd100);
    wait_done();
    @(posedge clk); #1;
    do_div(1'b1, 32'd13, 32'd4, 32'd3, 32'd1);
    wait_done();
    @(posedge clk); #1;
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
    wait_done();
    @(posedge clk); #1;
    do_div(1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF);
    wait_done();
    @(posedge clk); #1;

    do_div(1'b0, 32'd50, 32'd7, 32'd7, 32'd1);
    repeat (9) @(posedge clk);
    #1;
    bus.start    = 1'b1;
    bus.dividend = 32'd9;
    bus.divisor  = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done();
    do_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0);
    wait_done();
    @(posedge clk); #1;

    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd1000;
    bus.divisor   = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_stall", {31'd0, bus.stall}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_q", bus.quotient, 32'd0);
    chk("abort_r", bus.remainder, 32'd0);
    chk("abort_dz", {31'd0, bus.div_by_zero}, 32'd0);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    do_div(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1);
    wait_done();
    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
